// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared definitions for the MIPS load/store unit. Provides the
//               memory opcodes, FSM state encoding, access-size encoding, the
//               default bus timeout, and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int DEFAULT_TIMEOUT_CYCLES = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_store;
        logic      is_signed;
        mem_size_e size;
    } mem_op_t;

    // Anything that is not one of the eight memory opcodes decodes as a no-op.
    function automatic mem_op_t decode_op(input logic [5:0] opcode);
        mem_op_t d;
        d           = '0;
        d.size      = SZ_WORD;
        case (opcode)
            OP_LB:  begin d.is_mem = 1'b1; d.is_signed = 1'b1; d.size = SZ_BYTE; end
            OP_LH:  begin d.is_mem = 1'b1; d.is_signed = 1'b1; d.size = SZ_HALF; end
            OP_LW:  begin d.is_mem = 1'b1; d.size = SZ_WORD; end
            OP_LBU: begin d.is_mem = 1'b1; d.size = SZ_BYTE; end
            OP_LHU: begin d.is_mem = 1'b1; d.size = SZ_HALF; end
            OP_SB:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = SZ_BYTE; end
            OP_SH:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = SZ_HALF; end
            OP_SW:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = SZ_WORD; end
            default: d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_aligned(input mem_size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~offset[0];
            default: return (offset == 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : load_store_unit_if
// Description : Data-memory bus between the load/store unit (master) and the
//               data memory (slave).
//   mem_req/mem_we  request and write strobe      mem_addr   word address
//   mem_wdata       lane-steered store data       mem_be     byte enables
//   mem_ack         completion from memory        mem_rdata  read word
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
// Module      : ls_align
// Description : Purely combinational lane logic for big-endian memory access
//               (offset 0 = bits [31:24]).
//   Store side: st_size_i/st_offset_i/st_data_i -> be_o, wdata_o
//   Load side : ld_size_i/ld_signed_i/ld_offset_i/rdata_i -> result_o
// Revision    : 1.0 - initial release
// ============================================================================
module ls_align
    import mips_pkg::*;
(
    input  mem_size_e   st_size_i,
    input  logic [1:0]  st_offset_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  mem_size_e   ld_size_i,
    input  logic        ld_signed_i,
    input  logic [1:0]  ld_offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store data is replicated across every lane; the byte enables pick the
    // lane the memory actually writes.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (st_size_i)
            SZ_BYTE: begin
                be_o    = 4'b1000 >> st_offset_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = st_offset_i[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = st_data_i;
            end
        endcase
    end

    always_comb begin
        w_byte   = 8'h0;
        w_half   = ld_offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        result_o = rdata_i;
        case (ld_offset_i)
            2'd0:    w_byte = rdata_i[31:24];
            2'd1:    w_byte = rdata_i[23:16];
            2'd2:    w_byte = rdata_i[15:8];
            default: w_byte = rdata_i[7:0];
        endcase
        case (ld_size_i)
            SZ_BYTE: result_o = {{24{ld_signed_i & w_byte[7]}}, w_byte};
            SZ_HALF: result_o = {{16{ld_signed_i & w_half[15]}}, w_half};
            default: result_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage load/store unit. Decodes the memory opcode, checks
//               alignment, runs one request on the data bus with a timeout,
//               and formats load data.
//   clk, reset (async, active-low)
//   issue/instruction/address/store_data : MEM-stage instruction
//   stall           : hold upstream pipeline
//   load_result/load_valid : formatted load data and completion pulse
//   misaligned/bus_error   : one-cycle fault pulses
//   mem             : data-memory bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic [31:0] instruction,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_result,
    output logic        load_valid,
    output logic        misaligned,
    output logic        bus_error,
    load_store_unit_if.master mem
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, wdata_q, load_result_q;
    logic [3:0]       be_q;
    logic             we_q, signed_q;
    mem_size_e        size_q;
    logic [1:0]       offset_q;
    logic             load_valid_q, misaligned_q, bus_error_q;

    mem_op_t     w_op;
    logic        w_aligned, w_start, w_misalign, w_ack, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ld_result;
    logic        w_unused_instr;

    assign w_op           = decode_op(instruction[31:26]);
    assign w_aligned      = is_aligned(w_op.size, address[1:0]);
    assign w_start        = (state_q == ST_IDLE) && issue && w_op.is_mem && w_aligned;
    assign w_misalign     = (state_q == ST_IDLE) && issue && w_op.is_mem && !w_aligned;
    assign w_ack          = (state_q == ST_REQ) && mem.mem_ack;
    assign w_timeout      = (state_q == ST_REQ) && !mem.mem_ack && (cnt_q == CNT_LAST);
    assign w_unused_instr = ^instruction[25:0];

    ls_align u_align (
        .st_size_i   (w_op.size),
        .st_offset_i (address[1:0]),
        .st_data_i   (store_data),
        .be_o        (w_be),
        .wdata_o     (w_wdata),
        .ld_size_i   (size_q),
        .ld_signed_i (signed_q),
        .ld_offset_i (offset_q),
        .rdata_i     (mem.mem_rdata),
        .result_o    (w_ld_result)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request attributes are frozen at IDLE->REQ so the bus stays stable while
    // upstream is free to change its inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            be_q          <= 4'b0000;
            we_q          <= 1'b0;
            signed_q      <= 1'b0;
            size_q        <= SZ_BYTE;
            offset_q      <= 2'b00;
            load_result_q <= 32'h0;
            load_valid_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            misaligned_q <= w_misalign;
            bus_error_q  <= w_timeout;
            load_valid_q <= w_ack && !we_q;
            if (w_start) begin
                addr_q   <= {address[31:2], 2'b00};
                wdata_q  <= w_wdata;
                be_q     <= w_be;
                we_q     <= w_op.is_store;
                signed_q <= w_op.is_signed;
                size_q   <= w_op.size;
                offset_q <= address[1:0];
            end
            // Read data is only valid on the ack cycle, so format it then.
            if (w_ack && !we_q) begin
                load_result_q <= w_ld_result;
            end
        end
    end

    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_we    = (state_q == ST_REQ) && we_q;
    assign mem.mem_be    = (state_q == ST_REQ) ? be_q : 4'b0000;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Loads release the pipeline in RESP so the next instruction picks up
    // the result; stores hold it one more cycle.
    assign stall       = w_start || (state_q == ST_REQ) || ((state_q == ST_RESP) && we_q);
    assign load_result = load_result_q;
    assign load_valid  = load_valid_q;
    assign misaligned  = misaligned_q;
    assign bus_error   = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: table of single
//               transactions plus hand-written timeout, back-to-back and
//               reset-abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [31:0] address = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        stall, load_valid, misaligned, bus_error;
    logic [31:0] load_result;

    load_store_unit_if mem ();

    load_store_unit #(.TIMEOUT_CYCLES(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue       (issue),
        .instruction (instruction),
        .address     (address),
        .store_data  (store_data),
        .stall       (stall),
        .load_result (load_result),
        .load_valid  (load_valid),
        .misaligned  (misaligned),
        .bus_error   (bus_error),
        .mem         (mem)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_result;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 17;
    vec_t        vecs[NV];
    vec_t        v;
    logic [31:0] last_result;
    int          n;

    initial begin
        //        op         addr          sdata         rdata        dly req we  exp_addr      be       wdata         result       mis
        vecs[0]  = '{6'b100000, 32'h0000_0103, 32'h0,        32'h1122_33F0, 2, 1, 0, 32'h0000_0100, 4'b0001, 32'h0,        32'hFFFF_FFF0, 0};
        vecs[1]  = '{6'b100100, 32'h0000_0101, 32'h0,        32'h1180_33F0, 0, 1, 0, 32'h0000_0100, 4'b0100, 32'h0,        32'h0000_0080, 0};
        vecs[2]  = '{6'b100000, 32'h0000_0200, 32'h0,        32'h7F00_0000, 1, 1, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'h0000_007F, 0};
        vecs[3]  = '{6'b100001, 32'h0000_0012, 32'h0,        32'h1234_8001, 0, 1, 0, 32'h0000_0010, 4'b0011, 32'h0,        32'hFFFF_8001, 0};
        vecs[4]  = '{6'b100101, 32'h0000_0020, 32'h0,        32'hF00D_1234, 3, 1, 0, 32'h0000_0020, 4'b1100, 32'h0,        32'h0000_F00D, 0};
        vecs[5]  = '{6'b100001, 32'h0000_0024, 32'h0,        32'h7FFF_0000, 0, 1, 0, 32'h0000_0024, 4'b1100, 32'h0,        32'h0000_7FFF, 0};
        vecs[6]  = '{6'b100011, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 1, 1, 0, 32'h0000_1000, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0};
        vecs[7]  = '{6'b101000, 32'h0000_0301, 32'h1234_56A5, 32'h0,        0, 1, 1, 32'h0000_0300, 4'b0100, 32'hA5A5_A5A5, 32'h0,        0};
        vecs[8]  = '{6'b101001, 32'h0000_0042, 32'h0000_ABCD, 32'h0,        1, 1, 1, 32'h0000_0040, 4'b0011, 32'hABCD_ABCD, 32'h0,        0};
        vecs[9]  = '{6'b101011, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,        0, 1, 1, 32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 32'h0,        0};
        vecs[10] = '{6'b100100, 32'h0000_0003, 32'h0,        32'hAABB_CCFE, 0, 1, 0, 32'h0000_0000, 4'b0001, 32'h0,        32'h0000_00FE, 0};
        vecs[11] = '{6'b100011, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[12] = '{6'b101001, 32'h0000_0043, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[13] = '{6'b100001, 32'h0000_0011, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[14] = '{6'b101011, 32'h0000_0002, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[15] = '{6'b000000, 32'h0000_0007, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0};
        vecs[16] = '{6'b100010, 32'h0000_0008, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0};

        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 32'h0;
        last_result   = 32'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_mem_req", {31'h0, mem.mem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_load_result", load_result, 32'h0);
        chk("rst_load_valid", {31'h0, load_valid}, 32'h0);
        chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
        chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
        reset = 1'b1;
        tick();

        // Table of single transactions
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            issue       = 1'b1;
            instruction = {v.op, 26'h0};
            address     = v.addr;
            store_data  = v.sdata;
            #1;
            chk($sformatf("v%0d_stall_issue", i), {31'h0, stall}, {31'h0, v.exp_req});
            tick();
            issue = 1'b0; instruction = 32'h0; address = 32'h0; store_data = 32'h0;
            #1;
            if (v.exp_req) begin
                chk($sformatf("v%0d_mem_req", i), {31'h0, mem.mem_req}, 32'h1);
                chk($sformatf("v%0d_mem_addr", i), mem.mem_addr, v.exp_addr);
                chk($sformatf("v%0d_mem_be", i), {28'h0, mem.mem_be}, {28'h0, v.exp_be});
                chk($sformatf("v%0d_mem_we", i), {31'h0, mem.mem_we}, {31'h0, v.exp_we});
                if (v.exp_we) chk($sformatf("v%0d_mem_wdata", i), mem.mem_wdata, v.exp_wdata);
                for (int d = 0; d < v.delay; d++) begin
                    tick();
                    chk($sformatf("v%0d_hold_req", i), {31'h0, mem.mem_req}, 32'h1);
                    chk($sformatf("v%0d_hold_addr", i), mem.mem_addr, v.exp_addr);
                    chk($sformatf("v%0d_hold_stall", i), {31'h0, stall}, 32'h1);
                end
                mem.mem_ack   = 1'b1;
                mem.mem_rdata = v.rdata;
                tick();
                mem.mem_ack   = 1'b0;
                mem.mem_rdata = ~v.rdata;
                #1;
                if (!v.exp_we) last_result = v.exp_result;
                chk($sformatf("v%0d_resp_req", i), {31'h0, mem.mem_req}, 32'h0);
                chk($sformatf("v%0d_resp_valid", i), {31'h0, load_valid}, {31'h0, !v.exp_we});
                chk($sformatf("v%0d_resp_stall", i), {31'h0, stall}, {31'h0, v.exp_we});
                chk($sformatf("v%0d_load_result", i), load_result, last_result);
                tick();
                chk($sformatf("v%0d_after_valid", i), {31'h0, load_valid}, 32'h0);
                chk($sformatf("v%0d_after_stall", i), {31'h0, stall}, 32'h0);
                chk($sformatf("v%0d_after_req", i), {31'h0, mem.mem_req}, 32'h0);
            end else begin
                chk($sformatf("v%0d_misaligned", i), {31'h0, misaligned}, {31'h0, v.exp_mis});
                chk($sformatf("v%0d_no_req", i), {31'h0, mem.mem_req}, 32'h0);
                chk($sformatf("v%0d_no_stall", i), {31'h0, stall}, 32'h0);
                tick();
                chk($sformatf("v%0d_mis_pulse_end", i), {31'h0, misaligned}, 32'h0);
                chk($sformatf("v%0d_still_no_req", i), {31'h0, mem.mem_req}, 32'h0);
            end
        end

        // Timeout: LHU with no ack holds mem_req for exactly 15 cycles
        issue = 1'b1; instruction = {6'b100101, 26'h0}; address = 32'h0000_0010;
        tick();
        issue = 1'b0; instruction = 32'h0; address = 32'h0;
        n = 0;
        while (mem.mem_req && n < 40) begin
            n++;
            if (load_valid) chk("to_no_valid_in_req", {31'h0, load_valid}, 32'h0);
            tick();
        end
        chk("to_req_cycles", n, 32'd15);
        chk("to_bus_error", {31'h0, bus_error}, 32'h1);
        chk("to_req_dropped", {31'h0, mem.mem_req}, 32'h0);
        chk("to_no_valid", {31'h0, load_valid}, 32'h0);
        chk("to_result_kept", load_result, last_result);
        tick();
        chk("to_bus_error_end", {31'h0, bus_error}, 32'h0);
        chk("to_idle_no_stall", {31'h0, stall}, 32'h0);

        // Back-to-back SW then LW; LW presented during the SW is ignored
        issue = 1'b1; instruction = {6'b101011, 26'h0}; address = 32'h0000_0050; store_data = 32'h1122_3344;
        tick();
        instruction = {6'b100011, 26'h0}; address = 32'h0000_0054;
        mem.mem_ack = 1'b1;
        #1;
        chk("bb_sw_we", {31'h0, mem.mem_we}, 32'h1);
        chk("bb_sw_addr", mem.mem_addr, 32'h0000_0050);
        chk("bb_sw_wdata", mem.mem_wdata, 32'h1122_3344);
        tick();
        mem.mem_ack = 1'b0;
        #1;
        chk("bb_resp_stall", {31'h0, stall}, 32'h1);
        chk("bb_resp_no_req", {31'h0, mem.mem_req}, 32'h0);
        chk("bb_resp_no_valid", {31'h0, load_valid}, 32'h0);
        tick();
        chk("bb_idle_no_req", {31'h0, mem.mem_req}, 32'h0);
        chk("bb_lw_stall", {31'h0, stall}, 32'h1);
        tick();
        issue = 1'b0; instruction = 32'h0; address = 32'h0;
        chk("bb_lw_req", {31'h0, mem.mem_req}, 32'h1);
        chk("bb_lw_addr", mem.mem_addr, 32'h0000_0054);
        chk("bb_lw_we", {31'h0, mem.mem_we}, 32'h0);
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h0BAD_F00D;
        tick();
        mem.mem_ack = 1'b0; mem.mem_rdata = 32'h0;
        #1;
        chk("bb_lw_valid", {31'h0, load_valid}, 32'h1);
        chk("bb_lw_result", load_result, 32'h0BAD_F00D);
        chk("bb_lw_stall_resp", {31'h0, stall}, 32'h0);
        tick();
        chk("bb_lw_valid_end", {31'h0, load_valid}, 32'h0);

        // Reset during REQ, then a late ack after release
        issue = 1'b1; instruction = {6'b100011, 26'h0}; address = 32'h0000_0080;
        tick();
        issue = 1'b0; instruction = 32'h0; address = 32'h0;
        chk("ra_req_before", {31'h0, mem.mem_req}, 32'h1);
        reset = 1'b0;
        #1;
        chk("ra_req_dropped", {31'h0, mem.mem_req}, 32'h0);
        chk("ra_stall_dropped", {31'h0, stall}, 32'h0);
        chk("ra_result_cleared", load_result, 32'h0);
        tick();
        reset = 1'b1;
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 1) mem.mem_ack = 1'b0;
            chk($sformatf("ra_no_valid_%0d", k), {31'h0, load_valid}, 32'h0);
            chk($sformatf("ra_no_bus_error_%0d", k), {31'h0, bus_error}, 32'h0);
            chk($sformatf("ra_no_req_%0d", k), {31'h0, mem.mem_req}, 32'h0);
        end
        chk("ra_result_zero", load_result, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 15, max cycles mem_req may wait for mem_ack.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 issue  input  1  MEM-stage instruction valid.
REQ-006 instruction  input  32  opcode in [31:26].
REQ-007 address  input  32  effective byte address.
REQ-008 store_data  input  32  register value to store.
REQ-009 stall  output  1  hold upstream pipeline.
REQ-010 load_result  output  32  formatted load data.
REQ-011 load_valid  output  1  one-cycle load-complete pulse.
REQ-012 misaligned  output  1  one-cycle alignment-fault pulse.
REQ-013 bus_error  output  1  one-cycle timeout pulse.
REQ-014 mem_req, mem_we  output  1 each  request and write strobe to data memory.
REQ-015 mem_addr  output  32  word address, bits [1:0] = 0.
REQ-016 mem_wdata  output  32  lane-steered store data; mem_be  output  4  byte enables, bit 3 = bits [31:24].
REQ-017 mem_ack  input  1  memory completion; mem_rdata  input  32  read word.

Function
REQ-018 Decode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011; other opcodes are no-ops (no stall, no request).
REQ-019 Byte order big-endian: offset 0 = bits [31:24], offset 3 = bits [7:0].
REQ-020 FSM states IDLE, REQ, RESP; IDLE->REQ on issue with aligned memory opcode; REQ->RESP on mem_ack; REQ->IDLE on timeout; RESP->IDLE unconditionally.
REQ-021 In REQ: mem_req=1; mem_addr, mem_we, mem_be, mem_wdata held constant (registered at IDLE->REQ) until ack or timeout.
REQ-022 mem_be: byte op offset k -> bit (3-k) only; half op offset 0 -> 1100, offset 2 -> 0011; word -> 1111; mem_wdata replicates low byte/half into all lanes.
REQ-023 Misaligned (half with address[0]=1; word with address[1:0]!=0): no request, misaligned=1 next cycle, FSM stays IDLE.
REQ-024 Loads: in RESP, load_valid=1 and load_result = selected lane, sign-extended (LB, LH) or zero-extended (LBU, LHU); mem_rdata is sampled on the ack cycle.
REQ-025 Stores: RESP pulses neither load_valid nor load_result change.
REQ-026 stall = 1 combinationally when issue with aligned memory opcode in IDLE, in REQ, and in RESP for stores only; stall = 0 in RESP for loads, so the next instruction advances with the result.
REQ-027 issue in REQ/RESP is ignored (upstream is stalled).
REQ-028 Timeout counter cleared on entering REQ; when it reaches TIMEOUT_CYCLES without ack, bus_error=1 one cycle, mem_req=0, FSM->IDLE, load_valid not asserted.
REQ-029 mem_ack outside REQ is ignored.
REQ-030 Latency: request visible the cycle after issue; load_valid the cycle after mem_ack.

Reset
REQ-031 reset low SHALL immediately force IDLE; all outputs 0, load_result 32'h0, counter 0.
REQ-032 Reset during REQ drops mem_req asynchronously; the aborted access produces no pulse after release.

Structure
REQ-033 Opcode constants, state encoding and default TIMEOUT_CYCLES SHALL live in shared package mips_pkg.
REQ-034 Lane steering, byte enables and extension SHALL be one combinational sub-module ls_align.

Verification
REQ-035 LB address 0x0000_0103, mem_rdata 0x1122_33F0 ack after 2 cycles -> mem_addr 0x100, mem_be 0001, load_result 0xFFFF_FFF0, one load_valid pulse.
REQ-036 SH address 0x0000_0042, store_data 0x0000_ABCD -> mem_we=1, mem_addr 0x40, mem_be 0011, mem_wdata 0xABCD_ABCD, stall until the cycle after ack.
REQ-037 LW address 0x0000_0006 -> misaligned pulse, mem_req never 1, stall 0 thereafter.
REQ-038 LHU address 0x0000_0010, no ack -> mem_req high 15 cycles, then bus_error pulse, IDLE, no load_valid.
REQ-039 reset low mid-REQ, then mem_ack after release -> mem_req 0 immediately, no load_valid or bus_error.
REQ-040 back-to-back SW then LW, ack in 1 cycle -> second request issues only after first completes, load_result correct.
